bus_cycle_controller: RTL and testbench

Sequences every 68k bus cycle after address decode: takes the decoded region selects and the address strobe, inserts the per-region wait states, and generates DTACK_L. It also supervises handshaked regions (DRAM, CAN bus) with a watchdog, and raises BERR_L for unmapped or timed-out cycles. It sits between the address decoder and the CPU's DTACK_L/BERR_L inputs.

---
 rtl/bus_ctrl_pkg.sv | 42 ++++
 rtl/cycle_timer.sv | 39 +++
 rtl/bus_cycle_controller.sv | 185 ++++++++++++++++++
 tb/tb_bus_cycle_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the 68k bus cycle controller.
package bus_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HSHAKE,
        ST_ACK,
        ST_BERR
    } state_t;

    // Decoded target of the current bus cycle
    typedef enum logic [2:0] {
        REG_NONE,
        REG_ROM,
        REG_RAM,
        REG_IO,
        REG_CAN,
        REG_DRAM
    } region_t;

    // Priority encoder: ROM > RAM > IO > CAN > DRAM. RAM beats DRAM where
    // the two decode windows overlap.
    function automatic region_t encode_region(
        input logic rom,
        input logic ram,
        input logic io,
        input logic can,
        input logic dram
    );
        region_t r;
        if (rom)       r = REG_ROM;
        else if (ram)  r = REG_RAM;
        else if (io)   r = REG_IO;
        else if (can)  r = REG_CAN;
        else if (dram) r = REG_DRAM;
        else           r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable up/down counter shared by the wait-state and watchdog phases.
module cycle_timer #(
    parameter int CNT_W  = 8,
    parameter int TC_VAL = 254
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic             inc,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(TC_VAL);

    logic [CNT_W-1:0] count;

    // Counter register: clear has priority, then load, then count down/up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - CNT_W'(1);
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign zero = (count == '0);
    assign tc   = (count == TC);

endmodule

// File: rtl/bus_cycle_controller.sv
// Sequences each 68k bus cycle: wait-state insertion, DTACK_L generation,
// handshake watchdog and bus-error signalling.
module bus_cycle_controller
    import bus_ctrl_pkg::*;
#(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 1,
    parameter int IO_WAIT  = 2,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic       Clk,
    input  logic       Reset_L,
    input  logic       AS_L,
    input  logic       OnChipRomSelect_H,
    input  logic       OnChipRamSelect_H,
    input  logic       IOSelect_H,
    input  logic       DramSelect_H,
    input  logic       CanBusSelect_H,
    input  logic       DramDtack_L,
    input  logic       CanBusDtack_L,
    output logic       DTACK_L,
    output logic       BERR_L,
    output logic       Busy_H,
    output logic       Timeout_H,
    output logic [7:0] ErrCount
);

    localparam logic [CNT_W-1:0] ROM_N = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_N = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_N  = CNT_W'(IO_WAIT);

    state_t           state;
    state_t           state_next;
    region_t          region_q;
    region_t          region_next;
    region_t          region_sel;
    logic             t_load;
    logic             t_dec;
    logic             t_inc;
    logic             t_clear;
    logic [CNT_W-1:0] t_load_val;
    logic             t_zero;
    logic             t_tc;
    logic             enter_berr;
    logic             timeout_evt;
    logic             timeout_d;
    logic             ready_l;

    // Wait-state count for the fixed-latency regions
    function automatic logic [CNT_W-1:0] region_wait(input region_t r);
        logic [CNT_W-1:0] n;
        case (r)
            REG_ROM: n = ROM_N;
            REG_RAM: n = RAM_N;
            REG_IO:  n = IO_N;
            default: n = '0;
        endcase
        return n;
    endfunction

    assign region_sel = encode_region(OnChipRomSelect_H, OnChipRamSelect_H,
                                      IOSelect_H, CanBusSelect_H, DramSelect_H);

    // Ready is taken from the region latched at the start of the cycle only
    assign ready_l = (region_q == REG_CAN) ? CanBusDtack_L : DramDtack_L;
    assign Busy_H  = (state != ST_IDLE);

    cycle_timer #(
        .CNT_W  (CNT_W),
        .TC_VAL (TIMEOUT - 1)
    ) u_timer (
        .clk      (Clk),
        .rst_n    (Reset_L),
        .load     (t_load),
        .dec      (t_dec),
        .inc      (t_inc),
        .clear    (t_clear),
        .load_val (t_load_val),
        .zero     (t_zero),
        .tc       (t_tc)
    );

    // State and latched-region registers
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= ST_IDLE;
            region_q <= REG_NONE;
        end else begin
            state    <= state_next;
            region_q <= region_next;
        end
    end

    // Next-state decode and timer control
    always_comb begin
        state_next  = state;
        region_next = region_q;
        t_load      = 1'b0;
        t_dec       = 1'b0;
        t_inc       = 1'b0;
        t_clear     = 1'b0;
        t_load_val  = '0;
        enter_berr  = 1'b0;
        timeout_evt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!AS_L) begin
                    region_next = region_sel;
                    case (region_sel)
                        REG_ROM, REG_RAM, REG_IO: begin
                            if (region_wait(region_sel) == '0) begin
                                state_next = ST_ACK;
                            end else begin
                                state_next = ST_WAIT;
                                t_load     = 1'b1;
                                t_load_val = region_wait(region_sel) - CNT_W'(1);
                            end
                        end
                        REG_CAN, REG_DRAM: begin
                            state_next = ST_HSHAKE;
                            t_clear    = 1'b1;
                        end
                        default: begin
                            state_next = ST_BERR;
                            enter_berr = 1'b1;
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                // A negated strobe aborts the cycle silently
                if (AS_L) begin
                    state_next = ST_IDLE;
                end else if (t_zero) begin
                    state_next = ST_ACK;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_HSHAKE: begin
                if (AS_L) begin
                    state_next = ST_IDLE;
                end else if (!ready_l) begin
                    state_next = ST_ACK;
                end else if (t_tc) begin
                    state_next  = ST_BERR;
                    enter_berr  = 1'b1;
                    timeout_evt = 1'b1;
                end else begin
                    t_inc = 1'b1;
                end
            end
            ST_ACK: begin
                if (AS_L) state_next = ST_IDLE;
            end
            ST_BERR: begin
                if (AS_L) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered CPU-facing outputs and error counter
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            DTACK_L   <= 1'b1;
            BERR_L    <= 1'b1;
            timeout_d <= 1'b0;
            Timeout_H <= 1'b0;
            ErrCount  <= 8'd0;
        end else begin
            // Strobe high in ACK/BERR releases the output on the same edge
            DTACK_L   <= !((state == ST_ACK)  && !AS_L);
            BERR_L    <= !((state == ST_BERR) && !AS_L);
            // Pulse lines up with the first clock of BERR_L low
            timeout_d <= timeout_evt;
            Timeout_H <= timeout_d;
            if (enter_berr && (ErrCount != 8'hFF)) begin
                ErrCount <= ErrCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench with a cycle-timing reference model for bus_cycle_controller.
module tb_bus_cycle_controller;

    localparam int ROM_WAIT = 1;
    localparam int RAM_WAIT = 1;
    localparam int IO_WAIT  = 2;
    localparam int TIMEOUT  = 255;
    localparam int CNT_W    = 8;

    logic       Clk = 1'b0;
    logic       Reset_L = 1'b0;
    logic       AS_L = 1'b1;
    logic       OnChipRomSelect_H = 1'b0;
    logic       OnChipRamSelect_H = 1'b0;
    logic       IOSelect_H = 1'b0;
    logic       DramSelect_H = 1'b0;
    logic       CanBusSelect_H = 1'b0;
    logic       DramDtack_L = 1'b1;
    logic       CanBusDtack_L = 1'b1;
    logic       DTACK_L;
    logic       BERR_L;
    logic       Busy_H;
    logic       Timeout_H;
    logic [7:0] ErrCount;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;
    bit cmp_en = 1'b0;

    bus_cycle_controller #(
        .ROM_WAIT (ROM_WAIT),
        .RAM_WAIT (RAM_WAIT),
        .IO_WAIT  (IO_WAIT),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk               (Clk),
        .Reset_L           (Reset_L),
        .AS_L              (AS_L),
        .OnChipRomSelect_H (OnChipRomSelect_H),
        .OnChipRamSelect_H (OnChipRamSelect_H),
        .IOSelect_H        (IOSelect_H),
        .DramSelect_H      (DramSelect_H),
        .CanBusSelect_H    (CanBusSelect_H),
        .DramDtack_L       (DramDtack_L),
        .CanBusDtack_L     (CanBusDtack_L),
        .DTACK_L           (DTACK_L),
        .BERR_L            (BERR_L),
        .Busy_H            (Busy_H),
        .Timeout_H         (Timeout_H),
        .ErrCount          (ErrCount)
    );

    always #5 Clk = ~Clk;

    initial forever begin
        @(posedge Clk);
        edge_no++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each cycle is described by the edge k where the strobe
    // was first seen low and the edge a from which the response is driven.
    // The response is visible after every edge e >= a while the strobe stays low.
    logic exp_dtack = 1'b1;
    logic exp_berr  = 1'b1;
    logic exp_busy  = 1'b0;
    logic exp_to    = 1'b0;
    logic [7:0] exp_err = 8'd0;
    int m_e = 0;
    int m_k = 0;
    int m_a = -1;
    int m_to_edge = -1;
    int m_err = 0;
    bit m_in = 1'b0;
    bit m_hs = 1'b0;
    bit m_can = 1'b0;
    bit m_berr = 1'b0;

    initial forever begin
        @(posedge Clk or negedge Reset_L);
        if (!Reset_L) begin
            m_in = 1'b0; m_err = 0; m_a = -1; m_to_edge = -1;
            exp_dtack = 1'b1; exp_berr = 1'b1; exp_busy = 1'b0; exp_to = 1'b0;
            exp_err = 8'd0;
        end else begin
            m_e++;
            exp_to = (m_e == m_to_edge);
            if (!m_in) begin
                exp_dtack = 1'b1; exp_berr = 1'b1; exp_busy = 1'b0;
                if (!AS_L) begin
                    m_in = 1'b1; m_k = m_e; m_hs = 1'b0; m_berr = 1'b0; exp_busy = 1'b1;
                    if (OnChipRomSelect_H)      m_a = m_e + 1 + ROM_WAIT;
                    else if (OnChipRamSelect_H) m_a = m_e + 1 + RAM_WAIT;
                    else if (IOSelect_H)        m_a = m_e + 1 + IO_WAIT;
                    else if (CanBusSelect_H) begin m_hs = 1'b1; m_can = 1'b1; m_a = -1; end
                    else if (DramSelect_H)   begin m_hs = 1'b1; m_can = 1'b0; m_a = -1; end
                    else begin
                        m_berr = 1'b1; m_a = m_e + 1;
                        m_err = (m_err < 255) ? m_err + 1 : 255;
                    end
                end
            end else if (AS_L) begin
                m_in = 1'b0; exp_dtack = 1'b1; exp_berr = 1'b1; exp_busy = 1'b0;
            end else begin
                if (m_hs && m_a < 0) begin
                    if ((m_can ? CanBusDtack_L : DramDtack_L) == 1'b0) begin
                        m_a = m_e + 1;
                    end else if (m_e == m_k + TIMEOUT) begin
                        m_a = m_e + 1; m_berr = 1'b1; m_to_edge = m_e + 1;
                        m_err = (m_err < 255) ? m_err + 1 : 255;
                    end
                end
                exp_busy  = 1'b1;
                exp_dtack = !(m_a >= 0 && m_e >= m_a && !m_berr);
                exp_berr  = !(m_a >= 0 && m_e >= m_a && m_berr);
            end
            exp_err = 8'(m_err);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge Clk);
        if (cmp_en && Reset_L) begin
            chk("cyc_dtack",   32'(DTACK_L),   32'(exp_dtack));
            chk("cyc_berr",    32'(BERR_L),    32'(exp_berr));
            chk("cyc_busy",    32'(Busy_H),    32'(exp_busy));
            chk("cyc_timeout", 32'(Timeout_H), 32'(exp_to));
            chk("cyc_errcnt",  32'(ErrCount),  32'(exp_err));
        end
    end

    // One bus cycle. sel = {rom, ram, io, can, dram}. Strobe is sampled low on
    // edges k..k+hold-1 and high on k+hold. Ready (both lines) is low from edge
    // k+rdy_at onwards (rdy_at<0: never). Offsets report the first edge k+j
    // after which the output was seen active (-1: never).
    task automatic bus_cycle(input logic [4:0] sel, input int hold, input int rdy_at,
                             output int k, output int fd, output int fb, output int ft);
        k = edge_no + 1; fd = -1; fb = -1; ft = -1;
        {OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H, DramSelect_H} = sel;
        AS_L = 1'b0;
        {CanBusDtack_L, DramDtack_L} = 2'b11;
        for (int j = 0; j < hold; j++) begin
            @(negedge Clk);
            if (DTACK_L === 1'b0 && fd < 0)   fd = j;
            if (BERR_L === 1'b0 && fb < 0)    fb = j;
            if (Timeout_H === 1'b1 && ft < 0) ft = j;
            if (rdy_at >= 0 && j + 1 >= rdy_at) {CanBusDtack_L, DramDtack_L} = 2'b00;
        end
        AS_L = 1'b1;
        @(negedge Clk);
        {OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H, DramSelect_H} = 5'b0;
        {CanBusDtack_L, DramDtack_L} = 2'b11;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "bench did not complete in time");
    end

    initial begin
        int k, fd, fb, ft;
        repeat (2) @(negedge Clk);
        chk("rst_dtack",   32'(DTACK_L),   32'd1);
        chk("rst_berr",    32'(BERR_L),    32'd1);
        chk("rst_busy",    32'(Busy_H),    32'd0);
        chk("rst_timeout", 32'(Timeout_H), 32'd0);
        chk("rst_errcnt",  32'(ErrCount),  32'd0);
        Reset_L = 1'b1;
        cmp_en  = 1'b1;
        while (edge_no < 9) @(negedge Clk);

        // ROM, strobe first low at edge 10
        bus_cycle(5'b10000, 5, -1, k, fd, fb, ft);
        chk("rom_start_edge", 32'(k), 32'd10);
        chk("rom_dtack_edge", 32'(k + fd), 32'd12);
        chk("rom_no_berr", 32'(fb), -32'sd1);
        chk("rom_released", 32'(DTACK_L), 32'd1);

        // RAM and DRAM together: RAM timing, DRAM ready never comes
        bus_cycle(5'b01001, 5, -1, k, fd, fb, ft);
        chk("ramdram_dtack", 32'(fd), 32'd2);
        chk("ramdram_no_berr", 32'(fb), -32'sd1);

        // IO beats CAN even when CAN is ready immediately
        bus_cycle(5'b00110, 6, 1, k, fd, fb, ft);
        chk("io_over_can_dtack", 32'(fd), 32'd3);

        // DRAM ready first sampled 5 clocks after the strobe
        bus_cycle(5'b00001, 9, 5, k, fd, fb, ft);
        chk("dram_dtack", 32'(fd), 32'd6);
        chk("dram_no_berr", 32'(fb), -32'sd1);

        // CAN ready right away: earliest handshake acknowledge
        bus_cycle(5'b00010, 5, 1, k, fd, fb, ft);
        chk("can_fast_dtack", 32'(fd), 32'd2);

        // CAN never ready: watchdog expiry
        bus_cycle(5'b00010, 260, -1, k, fd, fb, ft);
        chk("can_to_berr", 32'(fb), 32'd256);
        chk("can_to_pulse", 32'(ft), 32'd256);
        chk("can_to_no_dtack", 32'(fd), -32'sd1);
        chk("can_to_errcnt", 32'(ErrCount), 32'd1);

        // Unmapped access
        bus_cycle(5'b00000, 3, -1, k, fd, fb, ft);
        chk("unmapped_berr", 32'(fb), 32'd1);
        chk("unmapped_errcnt", 32'(ErrCount), 32'd2);

        // IO cycle aborted during wait states
        bus_cycle(5'b00100, 2, -1, k, fd, fb, ft);
        chk("io_abort_dtack", 32'(fd), -32'sd1);
        chk("io_abort_berr", 32'(fb), -32'sd1);
        chk("io_abort_errcnt", 32'(ErrCount), 32'd2);
        chk("io_abort_idle", 32'(Busy_H), 32'd0);

        // Full IO cycle
        bus_cycle(5'b00100, 6, -1, k, fd, fb, ft);
        chk("io_dtack", 32'(fd), 32'd3);

        // Asynchronous reset while acknowledging
        OnChipRomSelect_H = 1'b1;
        AS_L = 1'b0;
        repeat (3) @(negedge Clk);
        chk("ack_before_reset", 32'(DTACK_L), 32'd0);
        #2;
        Reset_L = 1'b0;
        AS_L = 1'b1;
        #1;
        chk("async_rst_dtack",  32'(DTACK_L),  32'd1);
        chk("async_rst_busy",   32'(Busy_H),   32'd0);
        chk("async_rst_errcnt", 32'(ErrCount), 32'd0);
        #1;
        Reset_L = 1'b1;
        OnChipRomSelect_H = 1'b0;
        @(negedge Clk);

        // Normal cycle after reset
        bus_cycle(5'b10000, 4, -1, k, fd, fb, ft);
        chk("post_rst_dtack", 32'(fd), 32'd2);

        // Error counter saturation
        for (int i = 0; i < 300; i++) bus_cycle(5'b00000, 2, -1, k, fd, fb, ft);
        chk("sat_last_berr", 32'(fb), 32'd1);
        chk("sat_errcnt", 32'(ErrCount), 32'd255);

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
